uart_tx_scheduler: RTL and testbench
====================================

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL have parameter KB_FIFO_DEPTH, default 16, keyboard byte FIFO depth (power of 2, 2..256).
REQ-002 SHALL have parameter BUSY_WAIT_MAX, default 4, the maximum number of cycles to wait for txBusy after txStart.
REQ-003 SHALL have ports, one per line:
- clk  in  1  system clock (100 MHz)
- rst  in  1  reset, asynchronous, active-low
- kbValid  in  1  one-cycle pulse, keyboard ASCII byte present
- kbData  in  8  keyboard ASCII byte
- rptValid  in  1  report-stream byte valid
- rptData  in  8  report-stream byte
- rptLast  in  1  current report byte ends its packet
- rptReady  out  1  report byte accepted this cycle
- txStart  out  1  one-cycle start pulse to the UART transmitter
- txData  out  8  byte to transmit, stable while in flight
- txBusy  in  1  transmitter busy
- kbFifoFull  out  1  keyboard FIFO full

Function
REQ-004 SHALL shift a keyboard byte into the FIFO on every kbValid cycle when the FIFO is not full; it SHALL discard the byte when the FIFO is full.
REQ-005 SHALL permit a FIFO push and pop in the same cycle, including when full (the pop frees the slot first) and when empty (no bypass; the byte is sent later).
REQ-006 SHALL implement the FSM IDLE -> SEND -> WAIT_BUSY -> WAIT_DONE -> IDLE.
REQ-007 In IDLE with at least one source ready, SHALL grant one source, latch its byte into txData and go to SEND next cycle.
- FIFO pop, or rptReady=1 for exactly that cycle.
REQ-008 SHALL assert txStart for exactly the one SEND cycle, then enter WAIT_BUSY.
REQ-009 WAIT_BUSY SHALL go to WAIT_DONE when txBusy=1, or to IDLE after BUSY_WAIT_MAX cycles without txBusy (byte counted as sent).
REQ-010 WAIT_DONE SHALL return to IDLE on the first cycle with txBusy=0; byte-to-byte gap is at most 2 idle clk cycles plus transmitter time.
REQ-011 Arbitration: round-robin per packet; a keyboard byte is one packet; a report packet spans up to and including the rptLast byte.
REQ-012 While a report packet is open, SHALL grant only the report source, even if rptValid drops; keyboard bytes queue in the FIFO.
REQ-013 When both sources are ready in IDLE with no open packet, SHALL grant the source not granted last; after reset, keyboard wins.
REQ-014 txData SHALL hold its latched value from grant until the next grant.

Reset
REQ-015 On rst=0, asynchronously: state IDLE, FIFO empty, pointers 0, txStart=0, txData=8'h00, rptReady=0, kbFifoFull=0, packet lock cleared, last-grant=report.
REQ-016 Reset mid-transmission SHALL abandon the byte; no txStart SHALL occur until at least one cycle after rst deasserts.

Configuration
REQ-017 SHALL support macro UART_TX_DROP_COUNT_EN.
- Defined: adds output dropCount[15:0], reset 0, incremented once per discarded keyboard byte, saturating at 16'hFFFF.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Structure
REQ-018 The FSM state enum and the UART byte-width constant SHALL live in the shared package.
REQ-019 SHALL contain one sub-module, sync_byte_fifo (parameterised depth, full/empty flags, simultaneous push/pop).

Verification
REQ-020 Single keyboard byte 8'h41, txBusy model high 3..10 cycles after start -> one txStart, txData=8'h41, back to IDLE.
REQ-021 Report packet 8'h1B,8'h5B,8'h30,8'h6E (last on 8'h6E) with a concurrent kbValid 8'h61 -> all four report bytes sent first, then 8'h61.
REQ-022 20 kbValid pulses while txBusy held high, depth 16 -> 16 bytes sent in order, kbFifoFull=1 on push 16; with the macro, dropCount=4.
REQ-023 Both sources continuously ready with single-byte report packets -> alternating grants K,R,K,R starting with K after reset.
REQ-024 txBusy never asserted -> return to IDLE BUSY_WAIT_MAX cycles after SEND, next byte proceeds.
REQ-025 rst pulsed low during WAIT_DONE with 3 bytes queued -> all outputs at reset values immediately, FIFO empty, no txStart afterwards without new input.

Source files
------------

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler: byte width, FSM state
// encodings, source identifiers and the round-robin pick helper.
package uart_tx_scheduler_pkg;

  // Width of one UART payload byte.
  localparam int UART_BYTE_W = 8;

  // Scheduler FSM states, kept as plain constants so the encoding stays fixed.
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_SEND      = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  // Byte sources competing for the transmitter.
  typedef enum logic {
    SRC_KB  = 1'b0,
    SRC_RPT = 1'b1
  } src_e;

  // Pick the next source: when both are ready, the one not granted last wins.
  function automatic src_e rr_pick(input logic kb_rdy, input logic rpt_rdy,
                                   input src_e last_src);
    if (kb_rdy && rpt_rdy) begin
      return (last_src == SRC_KB) ? SRC_RPT : SRC_KB;
    end else if (rpt_rdy) begin
      return SRC_RPT;
    end else begin
      return SRC_KB;
    end
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_sync_byte_fifo.sv
// sync_byte_fifo: single-clock byte FIFO with full/empty flags.
// Read data is show-ahead (head entry always visible) so the scheduler can
// latch it in the same cycle it pops. A pop frees its slot before the push in
// the same cycle, so push+pop while full is accepted; pop while empty is ignored.
module sync_byte_fifo
  import uart_tx_scheduler_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [UART_BYTE_W-1:0] wr_data,
  input  logic                   pop,
  output logic [UART_BYTE_W-1:0] rd_data,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [UART_BYTE_W-1:0] mem [DEPTH];
  logic [AW:0]            wr_ptr_reg;
  logic [AW:0]            rd_ptr_reg;
  logic                   pop_ok;
  logic                   push_ok;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rd_data = mem[rd_ptr_reg[AW-1:0]];

  // Storage write; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  // Pointer advance on accepted push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: merges a keyboard byte stream (buffered in a FIFO) and a
// packetised report stream onto one UART transmitter. Packets are arbitrated
// round-robin; an open report packet locks the grant until its last byte.
// A new byte is only granted while the transmitter reports not busy.
// Optional macro UART_TX_DROP_COUNT_EN adds the dropCount output, a saturating
// count of keyboard bytes discarded because the FIFO was full.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int KB_FIFO_DEPTH = 16,
  parameter int BUSY_WAIT_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   kbValid,
  input  logic [UART_BYTE_W-1:0] kbData,
  input  logic                   rptValid,
  input  logic [UART_BYTE_W-1:0] rptData,
  input  logic                   rptLast,
  output logic                   rptReady,
  output logic                   txStart,
  output logic [UART_BYTE_W-1:0] txData,
  input  logic                   txBusy,
  output logic                   kbFifoFull
`ifdef UART_TX_DROP_COUNT_EN
  ,
  output logic [15:0]            dropCount
`endif
);

  localparam int WCW = (BUSY_WAIT_MAX > 1) ? $clog2(BUSY_WAIT_MAX) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(BUSY_WAIT_MAX - 1);

  logic [1:0]             state_reg;
  logic [1:0]             state_next;
  logic [WCW-1:0]         wait_cnt_reg;
  logic [UART_BYTE_W-1:0] tx_data_reg;
  src_e                   last_src_reg;
  logic                   pkt_open_reg;
  logic                   armed_reg;

  logic [UART_BYTE_W-1:0] kb_head;
  logic                   kb_full;
  logic                   kb_empty;
  logic                   kb_rdy;
  logic                   rpt_rdy;
  logic                   can_grant;
  src_e                   grant_src;
  logic                   kb_pop;
  logic                   rpt_take;
  logic                   wait_last;

  sync_byte_fifo #(
    .DEPTH(KB_FIFO_DEPTH)
  ) u_kb_fifo (
    .clk    (clk),
    .rst_n  (rst),
    .push   (kbValid),
    .wr_data(kbData),
    .pop    (kb_pop),
    .rd_data(kb_head),
    .full   (kb_full),
    .empty  (kb_empty)
  );

  // Grant decision: an open report packet masks the keyboard source; armed_reg
  // keeps every handshake quiet until one full cycle after reset release.
  always_comb begin
    kb_rdy    = !kb_empty && !pkt_open_reg;
    rpt_rdy   = rptValid;
    can_grant = (state_reg == ST_IDLE) && armed_reg && !txBusy && (kb_rdy || rpt_rdy);
    grant_src = rr_pick(kb_rdy, rpt_rdy, last_src_reg);
    kb_pop    = can_grant && (grant_src == SRC_KB);
    rpt_take  = can_grant && (grant_src == SRC_RPT);
  end

  assign wait_last  = (wait_cnt_reg == WAIT_LAST);
  assign rptReady   = rpt_take;
  assign txStart    = (state_reg == ST_SEND);
  assign txData     = tx_data_reg;
  assign kbFifoFull = kb_full;

  // Next-state logic for IDLE -> SEND -> WAIT_BUSY -> WAIT_DONE -> IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (can_grant) begin
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        state_next = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (txBusy) begin
          state_next = ST_WAIT_DONE;
        end else if (wait_last) begin
          // Transmitter never acknowledged; treat the byte as sent.
          state_next = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (!txBusy) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register and busy-wait timeout counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      wait_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_SEND) begin
        wait_cnt_reg <= '0;
      end else if ((state_reg == ST_WAIT_BUSY) && !txBusy && !wait_last) begin
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
      end
    end
  end

  // Grant bookkeeping: latch the byte, remember the winner, track packet lock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_data_reg  <= '0;
      last_src_reg <= SRC_RPT;
      pkt_open_reg <= 1'b0;
      armed_reg    <= 1'b0;
    end else begin
      armed_reg <= 1'b1;
      if (kb_pop) begin
        tx_data_reg  <= kb_head;
        last_src_reg <= SRC_KB;
      end else if (rpt_take) begin
        tx_data_reg  <= rptData;
        last_src_reg <= SRC_RPT;
        pkt_open_reg <= !rptLast;
      end
    end
  end

`ifdef UART_TX_DROP_COUNT_EN
  logic        kb_drop;
  logic [15:0] drop_cnt_reg;

  // A keyboard byte is lost when the FIFO is full and no pop frees a slot.
  assign kb_drop   = kbValid && kb_full && !kb_pop;
  assign dropCount = drop_cnt_reg;

  // Saturating discarded-byte counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_reg <= '0;
    end else if (kb_drop && (drop_cnt_reg != 16'hFFFF)) begin
      drop_cnt_reg <= drop_cnt_reg + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: tests push expected bytes into a
// queue, a monitor pops and compares on every txStart.
module tb_uart_tx_scheduler;

  localparam int DEPTH = 16;
  localparam int BWM   = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       kbValid;
  logic [7:0] kbData;
  logic       rptValid;
  logic [7:0] rptData;
  logic       rptLast;
  logic       rptReady;
  logic       txStart;
  logic [7:0] txData;
  logic       txBusy;
  logic       kbFifoFull;
`ifdef UART_TX_DROP_COUNT_EN
  logic [15:0] dropCount;
`endif

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int start_count = 0;
  int start_cycles[$];
  logic [7:0] exp_q[$];
  logic [8:0] rpt_q[$];
  int busy_mode = 1;   // 1: transmitter model pulses txBusy after each start, 0: never busy
  bit busy_hold = 1'b0;
  int tcnt = 0;

  uart_tx_scheduler #(
    .KB_FIFO_DEPTH(DEPTH),
    .BUSY_WAIT_MAX(BWM)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .kbValid   (kbValid),
    .kbData    (kbData),
    .rptValid  (rptValid),
    .rptData   (rptData),
    .rptLast   (rptLast),
    .rptReady  (rptReady),
    .txStart   (txStart),
    .txData    (txData),
    .txBusy    (txBusy),
    .kbFifoFull(kbFifoFull)
`ifdef UART_TX_DROP_COUNT_EN
    ,
    .dropCount (dropCount)
`endif
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Transmitter model: busy from 2 to 9 edges after a start, or held by busy_hold.
  initial begin
    txBusy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (busy_mode == 1 && txStart) tcnt = 1;
      else if (tcnt != 0) tcnt++;
      txBusy = busy_hold || (tcnt >= 3 && tcnt <= 9);
      if (tcnt >= 10) tcnt = 0;
    end
  end

  // Monitor: one line per transmitted byte, compared against the scoreboard.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && txStart === 1'b1) begin
        start_count++;
        start_cycles.push_back(cycle);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_txStart: got txData=%02h, required no start", txData);
        end else begin
          e = exp_q.pop_front();
          if (txData !== e) begin
            errors++;
            $display("FAIL tx_byte: got txData=%02h required %02h", txData, e);
          end else begin
            $display("tx byte %02h at cycle %0d ok", txData, cycle);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end else begin
      $display("check %s = %0h ok", name, act);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_kb(input logic [7:0] v);
    kbValid = 1'b1;
    kbData  = v;
    @(posedge clk);
    #1;
    kbValid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int maxc);
    int n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({name, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Drive queued report bytes, each held until the DUT accepts it.
  task automatic rpt_drive();
    logic [8:0] item;
    int n;
    while (rpt_q.size() > 0) begin
      item     = rpt_q.pop_front();
      rptValid = 1'b1;
      rptData  = item[7:0];
      rptLast  = item[8];
      n = 0;
      @(negedge clk);
      while (!rptReady && n < 300) begin
        @(negedge clk);
        n++;
      end
      if (!rptReady) begin
        checks++;
        errors++;
        $display("FAIL rpt_handshake: rptReady=0 after %0d cycles, required 1", n);
      end
      @(posedge clk);
      #1;
    end
    rptValid = 1'b0;
    rptLast  = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    wait_cycles(2);
  endtask

  initial begin
    int base;
    int d;
    rst = 1'b0; kbValid = 1'b0; kbData = 8'h00;
    rptValid = 1'b1; rptData = 8'hEE; rptLast = 1'b1;

    // Reset values, with a report byte pending to prove rptReady stays low.
    #12;
    check("rst_txStart", txStart, 0);
    check("rst_txData", txData, 8'h00);
    check("rst_rptReady", rptReady, 0);
    check("rst_kbFifoFull", kbFifoFull, 0);
`ifdef UART_TX_DROP_COUNT_EN
    check("rst_dropCount", dropCount, 0);
`endif
    rptValid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    wait_cycles(3);
    check("post_rst_no_start", start_count, 0);

    // Single keyboard byte through a normal busy handshake.
    busy_mode = 1;
    base = start_count;
    exp_q.push_back(8'h41);
    push_kb(8'h41);
    wait_drain("single_kb", 100);
    wait_cycles(15);
    check("single_kb_starts", start_count - base, 1);
    check("single_kb_txData_hold", txData, 8'h41);

    // Report packet locks out a concurrent keyboard byte until rptLast.
    exp_q.push_back(8'h1B); exp_q.push_back(8'h5B);
    exp_q.push_back(8'h30); exp_q.push_back(8'h6E); exp_q.push_back(8'h61);
    rpt_q.push_back({1'b0, 8'h1B}); rpt_q.push_back({1'b0, 8'h5B});
    rpt_q.push_back({1'b0, 8'h30}); rpt_q.push_back({1'b1, 8'h6E});
    fork
      rpt_drive();
      push_kb(8'h61);
    join
    wait_drain("rpt_packet", 400);
    wait_cycles(15);

    // Transmitter never busy: timeout path, start-to-start spacing BWM+2.
    busy_mode = 0;
    start_cycles.delete();
    exp_q.push_back(8'hD1); exp_q.push_back(8'hD2);
    push_kb(8'hD1);
    push_kb(8'hD2);
    wait_drain("no_busy", 100);
    d = (start_cycles.size() >= 2) ? (start_cycles[1] - start_cycles[0]) : -1;
    check("no_busy_start_interval", d, BWM + 2);
    wait_cycles(10);

    // Fill the FIFO while the transmitter is held busy; excess bytes drop.
    busy_mode = 1;
    busy_hold = 1'b1;
    wait_cycles(2);
    for (int i = 0; i < 20; i++) begin
      kbValid = 1'b1;
      kbData  = 8'h80 + 8'(i);
      if (i < DEPTH) exp_q.push_back(8'h80 + 8'(i));
      @(posedge clk);
      #1;
      if (i == DEPTH - 2) check("fifo_full_after_15", kbFifoFull, 0);
      if (i == DEPTH - 1) check("fifo_full_after_16", kbFifoFull, 1);
    end
    kbValid = 1'b0;
    check("fifo_full_after_20", kbFifoFull, 1);
`ifdef UART_TX_DROP_COUNT_EN
    check("drop_count", dropCount, 4);
`endif
    busy_hold = 1'b0;
    wait_drain("fifo_fill", 1500);
    wait_cycles(15);
    check("fifo_full_after_drain", kbFifoFull, 0);

    // Round-robin: both sources ready, keyboard first after reset.
    do_reset();
    busy_hold = 1'b1;
    wait_cycles(2);
    exp_q.push_back(8'h4B); exp_q.push_back(8'h52);
    exp_q.push_back(8'h6B); exp_q.push_back(8'h72);
    exp_q.push_back(8'h4C); exp_q.push_back(8'h53);
    rpt_q.push_back({1'b1, 8'h52}); rpt_q.push_back({1'b1, 8'h72});
    rpt_q.push_back({1'b1, 8'h53});
    fork
      rpt_drive();
      begin
        push_kb(8'h4B);
        push_kb(8'h6B);
        push_kb(8'h4C);
        wait_cycles(2);
        busy_hold = 1'b0;
      end
    join
    wait_drain("round_robin", 400);
    wait_cycles(15);

    // Reset during WAIT_DONE with three bytes still queued.
    exp_q.push_back(8'hC0);
    kbValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      kbData = 8'hC0 + 8'(i);
      @(posedge clk);
      #1;
    end
    kbValid = 1'b0;
    d = 0;
    while (txBusy !== 1'b1 && d < 50) begin
      @(posedge clk);
      #1;
      d++;
    end
    check("mid_tx_busy_seen", txBusy, 1);
    wait_cycles(2);
    check("pre_rst_txData", txData, 8'hC0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_txStart", txStart, 0);
    check("mid_rst_txData", txData, 8'h00);
    check("mid_rst_rptReady", rptReady, 0);
    check("mid_rst_kbFifoFull", kbFifoFull, 0);
    check("mid_rst_pending", exp_q.size(), 0);
    base = start_count;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    wait_cycles(30);
    check("post_rst_starts", start_count - base, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
